// File: rtl/hskbus_uart_tx.sv
`timescale 1ns/1ps
// hskbus_uart_tx: 8N1 byte transmitter for the shared hskbus line.
// Bytes arrive on a valid/ready stream grouped into packets by s_tlast_i.
// A new packet may only start once the bus has been quiet for HOLDOFF_CLKS
// clocks. Bytes inside an open packet are sent back to back. A packet is
// followed by GAP_BITS idle bit-times.
module hskbus_uart_tx #(
    parameter int CLKS_PER_BIT = 160,
    parameter int GAP_BITS     = 2,
    parameter int HOLDOFF_CLKS = 1600
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] s_tdata_i,
    input  logic       s_tvalid_i,
    input  logic       s_tlast_i,
    output logic       s_tready_o,
    input  logic       bus_rx_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic [7:0] tx_bytes_o
);
    localparam int CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GAP_CLKS = GAP_BITS * CLKS_PER_BIT;
    localparam int GAP_W    = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam int HOLD_W   = ($clog2(HOLDOFF_CLKS + 1) > 11) ? $clog2(HOLDOFF_CLKS + 1) : 11;
    localparam bit HAS_GAP  = (GAP_BITS > 0);

    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CLKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CLKS);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t              state_r;
    logic                sync_meta_r;
    logic                sync_r;
    logic                sync_prev_r;
    logic [CNT_W-1:0]    bit_cnt_r;
    logic [GAP_W-1:0]    gap_cnt_r;
    logic [2:0]          bit_idx_r;
    logic [7:0]          data_r;
    logic                last_r;
    logic                open_r;
    logic [HOLD_W-1:0]   holdoff_r;
    logic                tready_r;
    logic                busy_r;
    logic                tx_r;
    logic [7:0]          tx_bytes_r;

    logic                bit_end_s;
    logic                gap_end_s;
    logic                accept_s;
    logic                fall_s;
    logic [HOLD_W-1:0]   holdoff_nxt_s;
    logic                open_nxt_s;
    logic                idle_nxt_s;

    assign s_tready_o = tready_r;
    assign tx_o       = tx_r;
    assign busy_o     = busy_r;
    assign tx_bytes_o = tx_bytes_r;

    // Two-flop synchronizer for the bus monitor plus a history flop for falling-edge detection
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_meta_r <= 1'b1;
            sync_r      <= 1'b1;
            sync_prev_r <= 1'b1;
        end else begin
            sync_meta_r <= bus_rx_i;
            sync_r      <= sync_meta_r;
            sync_prev_r <= sync_r;
        end
    end

    // Next-cycle view of holdoff, packet-open and idle, so that ready/busy can be registered
    always_comb begin
        bit_end_s     = (bit_cnt_r == BIT_LAST);
        gap_end_s     = (gap_cnt_r == GAP_LAST);
        accept_s      = s_tvalid_i & tready_r;
        fall_s        = sync_prev_r & ~sync_r;
        holdoff_nxt_s = HOLD_ZERO;
        open_nxt_s    = open_r;
        idle_nxt_s    = 1'b1;

        // Foreign traffic restarts the quiet window only between packets
        if (fall_s && !open_r) begin
            holdoff_nxt_s = HOLD_LOAD;
        end else if (holdoff_r != HOLD_ZERO) begin
            holdoff_nxt_s = holdoff_r - HOLD_W'(1);
        end else begin
            holdoff_nxt_s = HOLD_ZERO;
        end

        if (accept_s && !s_tlast_i) begin
            open_nxt_s = 1'b1;
        end else if (state_r == ST_STOP && bit_end_s && last_r) begin
            open_nxt_s = 1'b0;
        end else begin
            open_nxt_s = open_r;
        end

        case (state_r)
            ST_IDLE:  idle_nxt_s = !accept_s;
            ST_START: idle_nxt_s = 1'b0;
            ST_DATA:  idle_nxt_s = 1'b0;
            ST_STOP:  idle_nxt_s = bit_end_s && !(last_r && HAS_GAP);
            ST_GAP:   idle_nxt_s = gap_end_s;
            default:  idle_nxt_s = 1'b1;
        endcase
    end

    // Transmit state machine: framing, bit timing, byte count and registered handshake outputs
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= {CNT_W{1'b0}};
            gap_cnt_r  <= {GAP_W{1'b0}};
            bit_idx_r  <= 3'd0;
            data_r     <= 8'd0;
            last_r     <= 1'b0;
            open_r     <= 1'b0;
            holdoff_r  <= HOLD_ZERO;
            tready_r   <= 1'b0;
            busy_r     <= 1'b0;
            tx_r       <= 1'b1;
            tx_bytes_r <= 8'd0;
        end else begin
            holdoff_r <= holdoff_nxt_s;
            open_r    <= open_nxt_s;
            tready_r  <= idle_nxt_s && (open_nxt_s || holdoff_nxt_s == HOLD_ZERO);
            busy_r    <= !idle_nxt_s || open_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    bit_cnt_r <= {CNT_W{1'b0}};
                    gap_cnt_r <= {GAP_W{1'b0}};
                    bit_idx_r <= 3'd0;
                    if (accept_s) begin
                        data_r  <= s_tdata_i;
                        last_r  <= s_tlast_i;
                        tx_r    <= 1'b0;
                        state_r <= ST_START;
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        bit_cnt_r <= {CNT_W{1'b0}};
                        bit_idx_r <= 3'd0;
                        tx_r      <= data_r[0];
                        state_r   <= ST_DATA;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        bit_cnt_r <= {CNT_W{1'b0}};
                        if (bit_idx_r == 3'd7) begin
                            tx_r    <= 1'b1;
                            state_r <= ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            tx_r      <= data_r[bit_idx_r + 3'd1];
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        bit_cnt_r  <= {CNT_W{1'b0}};
                        tx_bytes_r <= tx_bytes_r + 8'd1;
                        if (last_r && HAS_GAP) begin
                            state_r <= ST_GAP;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    tx_r <= 1'b1;
                    if (gap_end_s) begin
                        gap_cnt_r <= {GAP_W{1'b0}};
                        state_r   <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hskbus_uart_tx.sv
`timescale 1ns/1ps
// Bench for hskbus_uart_tx: directed frame/holdoff/reset scenarios on a
// default-parameter instance, plus a randomized 256-packet run on a
// fast-timing instance decoded by a behavioural UART receiver.
module tb_hskbus_uart_tx;
    localparam int CPB    = 160;
    localparam int GAPB   = 2;
    localparam int HOLD   = 1600;
    localparam int F_CPB  = 4;
    localparam int F_GAPB = 1;
    localparam int F_HOLD = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_tdata;
    logic       s_tvalid, s_tlast, s_tready, bus_rx, tx, busy;
    logic [7:0] tx_bytes;
    logic [7:0] f_tdata;
    logic       f_tvalid, f_tlast, f_tready, f_bus_rx, f_tx, f_busy;
    logic [7:0] f_tx_bytes;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_bytes = 0;
    int f_frame_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hskbus_uart_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAPB), .HOLDOFF_CLKS(HOLD)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid),
        .s_tlast_i(s_tlast), .s_tready_o(s_tready), .bus_rx_i(bus_rx), .tx_o(tx),
        .busy_o(busy), .tx_bytes_o(tx_bytes));

    hskbus_uart_tx #(.CLKS_PER_BIT(F_CPB), .GAP_BITS(F_GAPB), .HOLDOFF_CLKS(F_HOLD)) u_fast (
        .clk_i(clk), .rst_n_i(rst_n), .s_tdata_i(f_tdata), .s_tvalid_i(f_tvalid),
        .s_tlast_i(f_tlast), .s_tready_o(f_tready), .bus_rx_i(f_bus_rx), .tx_o(f_tx),
        .busy_o(f_busy), .tx_bytes_o(f_tx_bytes));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a byte and wait (bounded) for acceptance; returns in the first start-bit cycle.
    task automatic send_main(input logic [7:0] d, input logic l, input logic hold, output int start_cyc);
        int w;
        s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
        w = 0;
        while (s_tready !== 1'b1 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        chk("tready_wait", 32'(s_tready === 1'b1), 32'd1);
        @(negedge clk);
        start_cyc = cyc;
        s_tdata  = 8'($urandom);
        s_tlast  = 1'($urandom_range(0, 1));
        s_tvalid = hold;
    endtask

    // Expected line level comes from the 8N1 frame {stop, data, start}, LSB sent first.
    task automatic check_frame(input logic [7:0] d, input logic pulse);
        logic [9:0] frame;
        int lvl_err;
        int ctl_err;
        frame = {1'b1, d, 1'b0};
        ctl_err = 0;
        for (int b = 0; b < 10; b++) begin
            lvl_err = 0;
            for (int k = 0; k < CPB; k++) begin
                if (pulse) bus_rx = (k >= 40 && k < 44) ? 1'b0 : 1'b1;
                if (tx !== frame[b]) lvl_err++;
                if (s_tready !== 1'b0 || busy !== 1'b1) ctl_err++;
                @(negedge clk);
            end
            chk($sformatf("tx_bit%0d_of_%02h", b, d), 32'(lvl_err), 32'd0);
        end
        bus_rx = 1'b1;
        chk("frame_ready_busy", 32'(ctl_err), 32'd0);
        exp_bytes = (exp_bytes + 1) % 256;
        chk("tx_bytes", 32'(tx_bytes), 32'(exp_bytes));
    endtask

    task automatic gap_check();
        int bad;
        bad = 0;
        for (int k = 0; k < GAPB * CPB; k++) begin
            if (s_tready !== 1'b0 || tx !== 1'b1) bad++;
            @(negedge clk);
        end
        chk("gap_quiet", 32'(bad), 32'd0);
        chk("gap_then_ready", 32'(s_tready), 32'd1);
    endtask

    // Behavioural UART receiver on the fast instance: mid-bit sampling after each start edge
    initial begin : fast_monitor
        int mcnt;
        bit mact;
        logic [7:0] msh;
        mact = 1'b0; mcnt = 0; msh = 8'd0;
        forever begin
            @(negedge clk);
            if (!mact) begin
                if (f_tx === 1'b0) begin
                    mact = 1'b1;
                    mcnt = 0;
                end
            end else begin
                mcnt++;
                if (mcnt == F_CPB / 2) begin
                    if (f_tx !== 1'b0) f_frame_err++;
                end else if (mcnt == 9 * F_CPB + F_CPB / 2) begin
                    if (f_tx !== 1'b1) f_frame_err++;
                    rx_q.push_back(msh);
                    mact = 1'b0;
                end else if (mcnt > F_CPB && (mcnt % F_CPB) == F_CPB / 2) begin
                    msh[mcnt / F_CPB - 1] = f_tx;
                end
            end
        end
    end

    initial begin
        logic [7:0] d;
        bit acc;
        int w, t0, t1, hi, mism;

        rst_n = 1'b0; s_tdata = 8'd0; s_tvalid = 1'b0; s_tlast = 1'b0; bus_rx = 1'b1;
        f_tdata = 8'd0; f_tvalid = 1'b0; f_tlast = 1'b0; f_bus_rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_tready", 32'(s_tready), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_tx_bytes", 32'(tx_bytes), 32'd0);
        chk("reset_f_tready", 32'(f_tready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(s_tready), 32'd1);

        // Single-byte packet 0xA5, followed by the inter-packet gap
        send_main(8'hA5, 1'b1, 1'b0, t0);
        check_frame(8'hA5, 1'b0);
        gap_check();

        // Three-byte packet, continuous valid, bus activity injected mid-packet
        send_main(8'h01, 1'b0, 1'b1, t0);
        check_frame(8'h01, 1'b1);
        send_main(8'h02, 1'b0, 1'b1, t1);
        chk("start_spacing_1_2", 32'(t1 - t0), 32'(10 * CPB + 1));
        check_frame(8'h02, 1'b1);
        send_main(8'h03, 1'b1, 1'b0, t0);
        chk("start_spacing_2_3", 32'(t0 - t1), 32'(10 * CPB + 1));
        check_frame(8'h03, 1'b0);
        gap_check();

        // Foreign falling edge while idle: ready withheld for the holdoff window
        bus_rx = 1'b0;
        hi = 0;
        for (int j = 1; j <= HOLD + 4; j++) begin
            @(negedge clk);
            if (j == 5) bus_rx = 1'b1;
            if (j >= 4 && j <= HOLD + 1 && s_tready !== 1'b0) hi++;
        end
        chk("holdoff_quiet", 32'(hi), 32'd0);
        chk("holdoff_release", 32'(s_tready), 32'd1);
        chk("holdoff_not_busy", 32'(busy), 32'd0);

        // Reset pulse during data bit 4 aborts the byte; the next byte is clean
        d = 8'h6C;
        send_main(d, 1'b1, 1'b0, t0);
        repeat (5 * CPB + 50) @(negedge clk);
        chk("pre_reset_bit4", 32'(tx), 32'(d[4]));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_bytes = 0;
        chk("abort_tx_high", 32'(tx), 32'd1);
        chk("abort_tx_bytes", 32'(tx_bytes), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        hi = 0;
        for (int k = 0; k < 12 * CPB; k++) begin
            if (tx !== 1'b1) hi++;
            @(negedge clk);
        end
        chk("abort_not_resumed", 32'(hi), 32'd0);
        chk("abort_no_count", 32'(tx_bytes), 32'd0);
        send_main(8'h96, 1'b1, 1'b0, t0);
        check_frame(8'h96, 1'b0);
        gap_check();

        // 256 random single-byte packets with random valid toggling on the fast instance
        for (int i = 0; i < 256; i++) begin
            d = 8'($urandom);
            acc = 1'b0;
            w = 0;
            while (!acc && w < 400) begin
                f_tdata  = d;
                f_tlast  = 1'b1;
                f_tvalid = 1'($urandom_range(0, 1));
                if (f_tvalid && f_tready === 1'b1) begin
                    acc = 1'b1;
                    chk("f_count_at_accept", 32'(f_tx_bytes), 32'(i % 256));
                    exp_q.push_back(d);
                end
                @(negedge clk);
                w++;
            end
            chk("f_accept_wait", 32'(acc), 32'd1);
            if (!acc) break;
        end
        f_tvalid = 1'b0;
        w = 0;
        while (rx_q.size() < exp_q.size() && w < 400) begin
            @(negedge clk);
            w++;
        end
        repeat (F_CPB + 2) @(negedge clk);
        chk("f_accepted", 32'(exp_q.size()), 32'd256);
        chk("f_rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
        mism = 0;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            if (rx_q[i] !== exp_q[i]) mism++;
        end
        chk("f_scoreboard", 32'(mism), 32'd0);
        chk("f_framing", 32'(f_frame_err), 32'd0);
        chk("f_wrap", 32'(f_tx_bytes), 32'(exp_q.size() % 256));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hskbus_uart_tx.md
HSKBUS_UART_TX -- requirements
Module: hskbus_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 160: clocks per UART bit (80 MHz / 500 kbps).
REQ-002 SHALL have parameter GAP_BITS, default 2: idle bit-times inserted after a byte marked last.
REQ-003 SHALL have parameter HOLDOFF_CLKS, default 1600: quiet clocks required after foreign bus activity before a new packet may start.
REQ-004 SHALL have port clk_i, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n_i, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port s_tdata_i, input, 8: byte to transmit.
REQ-007 SHALL have port s_tvalid_i, input, 1: s_tdata_i/s_tlast_i valid.
REQ-008 SHALL have port s_tlast_i, input, 1: byte is last of a packet.
REQ-009 SHALL have port s_tready_o, output, 1: block accepts byte this cycle.
REQ-010 SHALL have port bus_rx_i, input, 1: asynchronous monitor of the shared hskbus line, idle high.
REQ-011 SHALL have port tx_o, output, 1: serial output, 8N1, LSB first, idle high.
REQ-012 SHALL have port busy_o, output, 1: high whenever state is not IDLE or a packet is open.
REQ-013 SHALL have port tx_bytes_o, output, 8: count of completed bytes, wraps.

Function
REQ-014 SHALL run a state machine with states IDLE, START, DATA, STOP, GAP.
REQ-015 SHALL synchronize bus_rx_i through two flops before any use; a falling edge is sync sample 1 then 0.
REQ-016 SHALL hold an 11-bit-or-wider holdoff counter; a synchronized falling edge of bus_rx_i while no packet is open SHALL load HOLDOFF_CLKS; otherwise it decrements to 0 and holds.
REQ-017 SHALL assert s_tready_o only in IDLE, and only when a packet is open or the holdoff counter is 0.
REQ-018 SHALL latch s_tdata_i and s_tlast_i on s_tvalid_i and s_tready_o both high and go to START on the next cycle.
REQ-019 SHALL, once a byte is accepted without s_tlast_i, mark the packet open; the packet closes when a byte with s_tlast_i completes STOP.
REQ-020 SHALL ignore bus_rx_i edges (no holdoff reload) while a packet is open.
REQ-021 SHALL drive tx_o low for exactly CLKS_PER_BIT clocks in START, then each of 8 data bits LSB first for CLKS_PER_BIT clocks in DATA, then high for CLKS_PER_BIT clocks in STOP.
REQ-022 SHALL register tx_o; the first start-bit clock is the cycle after acceptance.
REQ-023 SHALL, at the last STOP clock, increment tx_bytes_o by 1 modulo 256 (255 -> 0).
REQ-024 SHALL go from STOP to GAP if the latched last flag is set, else to IDLE.
REQ-025 SHALL hold tx_o high in GAP for GAP_BITS*CLKS_PER_BIT clocks, then go to IDLE; GAP_BITS = 0 SHALL skip GAP.
REQ-026 SHALL give a byte period of 10*CLKS_PER_BIT+1 clocks under continuous s_tvalid_i within a packet.
REQ-027 SHALL keep s_tready_o low in all non-IDLE states; s_tdata_i changes outside acceptance SHALL NOT affect the byte in flight.
REQ-028 SHALL use a bit-time counter of ceil(log2(CLKS_PER_BIT)) bits and a 3-bit data index; no combinational path from any input to tx_o.

Reset
REQ-029 SHALL, with rst_n_i low at a clock edge, set tx_o=1, s_tready_o=0, busy_o=0, tx_bytes_o=0, state IDLE, packet closed, holdoff counter 0, synchronizer flops 1.
REQ-030 SHALL abort any byte in progress on reset with tx_o high on the next cycle, no count increment, and the byte not resumed.

Verification
REQ-031 SHALL verify: 0xA5 with tlast=1 after reset -> tx_o low 160 clk, bits 1,0,1,0,0,1,0,1 at 160 clk each, high 160 clk, tx_bytes_o=1, s_tready_o low for a further 320 clk.
REQ-032 SHALL verify: 3-byte packet 0x01,0x02,0x03 (tlast on 0x03) with continuous valid -> start bits 1601 clk apart, no holdoff after bus_rx_i pulses injected mid-packet, tx_bytes_o=3.
REQ-033 SHALL verify: bus_rx_i falls at cycle T with block idle and no packet open -> s_tready_o low until T+2+1600 (±1), then high.
REQ-034 SHALL verify: rst_n_i low for 1 clk during DATA bit 4 -> tx_o=1 next cycle, tx_bytes_o=0, next byte transmits cleanly.
REQ-035 SHALL verify: 256 single-byte packets -> tx_bytes_o wraps to 0; s_tvalid_i toggled randomly -> no byte lost or duplicated versus scoreboard.
